// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift unit: the datapath 2-bit shift
// operation codes and the controller state encoding.
package shifter_pkg;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift of a WIDTH-bit value according to the datapath shift
// code. Also reports the bit that falls off the end (0 for SH_NONE).
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] val,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             bit_out
);

    // Single-step shift; ASR keeps the current MSB, which is the captured
    // sign bit because every ASR step preserves it.
    always_comb begin
        res     = val;
        bit_out = 1'b0;
        case (op)
            SH_LSL: begin
                res     = {val[WIDTH-2:0], 1'b0};
                bit_out = val[WIDTH-1];
            end
            SH_LSR: begin
                res     = {1'b0, val[WIDTH-1:1]};
                bit_out = val[0];
            end
            SH_ASR: begin
                res     = {val[WIDTH-1], val[WIDTH-1:1]};
                bit_out = val[0];
            end
            default: begin
                res     = val;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: shifts a WIDTH-bit operand one position per clock.
// Handshake: start is accepted only in IDLE or DONE (captures bin/shift/amount);
// busy is high while shifting; done is a one-cycle pulse marking out valid.
// out holds its value until the next accepted start.
// Optional feature macro CARRY_OUT_EN adds the cout port (last bit shifted out).
// state_dbg exposes the controller state for observation.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       state_dbg
`ifdef CARRY_OUT_EN
    ,
    output logic             cout
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op;
    logic [AMT_W-1:0] count;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] step_res;
    logic             step_carry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .val     (out),
        .op      (op),
        .res     (step_res),
        .bit_out (step_carry)
    );

    assign state_dbg = state;

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic plus busy/done and datapath enables.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (count != '0) step = 1'b1;
                else             state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result, operation and remaining-count registers. SH_NONE forces a zero
    // count so the result is the captured operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out   <= '0;
            op    <= SH_NONE;
            count <= '0;
        end else if (load) begin
            out   <= bin;
            op    <= shift;
            count <= (shift == SH_NONE) ? '0 : amount;
        end else if (step) begin
            out   <= step_res;
            count <= count - AMT_W'(1);
        end
    end

`ifdef CARRY_OUT_EN
    // Carry register: last bit shifted out, cleared on accept, held with out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cout <= 1'b0;
        else if (load) cout <= 1'b0;
        else if (step) cout <= step_carry;
    end
`else
    logic unused_carry;
    assign unused_carry = step_carry;
`endif

endmodule
